lut_cfg_sched: RTL
==================

Name: lut_cfg_sched

Overview:
Configuration scheduler for the 5-input LUT block.
- Accepts register writes for FUNC and the A..E input edge modes into shadow registers.
- Applies them to the LUT atomically, either immediately, on a commit strobe, or on a trigger edge, pulsing the LUT's per-field WSTB lines.
- Sits between the register bus decode and the LUT instance, so a multi-field LUT reconfiguration never produces glitch states on out_o.

Parameters:
FUNC_RST, 32'h0000_0000, reset value of shadow and live FUNC
EDGE_RST, 2'b00, reset value of shadow and live A..E
ARM_TIMEOUT, 0, cycles ARMED may wait for a trigger before giving up (0 = wait forever)

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous, active-low reset
reg_addr_i  in  3  field select: 0=FUNC, 1=A, 2=B, 3=C, 4=D, 5=E, 6..7 unused
reg_data_i  in  32  write data (edge fields use bits [1:0])
reg_wstb_i  in  1  write strobe, one cycle per write
mode_i  in  2  0=immediate, 1=on commit, 2=on trigger edge, 3=reserved (treated as 1)
commit_i  in  1  commit/arm strobe
trig_i  in  1  trigger level input (rising edge used)
abort_i  in  1  cancel an armed commit
func_o  out  32  live FUNC to LUT
func_wstb_o  out  1  FUNC update pulse
a_o, b_o, c_o, d_o, e_o  out  2 each  live edge modes to LUT
a_wstb_o, b_wstb_o, c_wstb_o, d_wstb_o, e_wstb_o  out  1 each  update pulses
pending_o  out  6  bit i set = field i written but not yet applied
busy_o  out  1  high in ARMED or APPLY
applied_o  out  1  one-cycle pulse when an apply occurs
err_o  out  1  one-cycle pulse on illegal write or timeout

Behaviour:
- Reset (async assert, sync release):
  - live and shadow regs = FUNC_RST / EDGE_RST
  - pending_o = 0
  - all wstb, applied_o, err_o, busy_o = 0
  - state IDLE
  - trig edge-detector history = 0
- Writes:
  - reg_wstb_i with addr 0..5 stores data into that shadow field and sets its pending bit; last write wins.
  - Edge data value 3, or addr 6..7: write ignored, err_o pulses next cycle.
  - Writes are accepted in every state.
- States: IDLE, ARMED, APPLY (APPLY lasts exactly one cycle).
- Immediate mode (mode_i=0, IDLE):
  - A write at cycle N goes directly to APPLY.
  - At N+1: live field updated, its wstb high for one cycle, applied_o high, pending bit cleared.
  - commit_i is ignored.
- Commit mode (mode_i=1/3): commit_i in IDLE at cycle N -> APPLY. At N+1:
  - every pending field is copied to live simultaneously, each with a one-cycle wstb
  - pending cleared, applied_o pulses
  - commit with pending=0 still pulses applied_o with no wstb
- Trigger mode (mode_i=2):
  - commit_i in IDLE -> ARMED, busy_o=1.
  - In ARMED, trig_i=1 at cycle N with trig_i=0 at N-1 -> APPLY, with outputs at N+1 as in commit mode.
  - A trig already high on entry to ARMED does not fire; a new rising edge is required.
- ARMED exits:
  - abort_i -> IDLE, pending kept, no apply.
  - ARM_TIMEOUT>0: counter starts at 0 on entry. When the count reaches ARM_TIMEOUT-1 without a trigger -> IDLE, err_o pulses, pending kept.
  - abort and trigger edge in the same cycle: abort wins.
- Simultaneous events:
  - A write and a commit/trigger in the same cycle: the write is included in the apply.
  - A write during the APPLY cycle stays pending for the next apply.
  - commit_i in ARMED or APPLY is ignored.
- mode_i is sampled only in IDLE; changes while ARMED take effect after return to IDLE.
- Live outputs change only in the APPLY cycle. wstb outputs are registered; the same cycle as the live value change.
- Reset mid-ARMED or mid-APPLY: everything returns to reset values; no partial apply is visible.

Decomposition:
- Shared package lut_pkg:
  - field index constants FUNC_IDX..E_IDX
  - edge-mode enum (RISE, FALL, EITHER, reserved)
  - mode enum (IMMED, COMMIT, TRIG)
  - NUM_FIELDS=6
- Sub-module lut_cfg_field: one shadow/live/pending/wstb slice, parameterised by width and reset value, instantiated 6 times. The FSM and timeout counter stay in the top level.

Test Plan:
- Reset with FUNC_RST=32'hFFFF0000: release reset_n_i -> func_o=32'hFFFF0000, all wstb 0, pending_o=0, busy_o=0.
- mode 0, write addr0 = 32'h0000_00FF at cycle N -> func_o=32'hFF and func_wstb_o=1 at N+1 only; applied_o pulse; pending_o=0.
- mode 1, write A=1, C=2, FUNC=32'h1234, then commit -> next cycle a_o=1, c_o=2, func_o=32'h1234; a/c/func wstb all pulse in the same cycle; b/d/e wstb stay 0.
- mode 2, ARM_TIMEOUT=0, commit with trig_i already 1 -> stays ARMED. trig low then high at N -> apply at N+1. A write B=2 issued the same cycle as the edge is included.
- mode 2, ARM_TIMEOUT=8, commit then no trigger -> IDLE after 8 cycles, err_o pulse, pending_o unchanged. Abort together with a trigger edge -> no apply.
- Write addr 1 data 3 -> err_o pulse, a_o and pending_o unchanged. Assert reset_n_i while ARMED -> IDLE, pending cleared.

Source files
------------

// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared types and constants for the LUT configuration scheduler
package lut_pkg;

    localparam int NUM_FIELDS = 6;

    localparam logic [2:0] FUNC_IDX = 3'd0;
    localparam logic [2:0] A_IDX    = 3'd1;
    localparam logic [2:0] B_IDX    = 3'd2;
    localparam logic [2:0] C_IDX    = 3'd3;
    localparam logic [2:0] D_IDX    = 3'd4;
    localparam logic [2:0] E_IDX    = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE   = 2'd0,
        EDGE_FALL   = 2'd1,
        EDGE_EITHER = 2'd2,
        EDGE_RSVD   = 2'd3
    } edge_mode_e;

    typedef enum logic [1:0] {
        MODE_IMMED  = 2'd0,
        MODE_COMMIT = 2'd1,
        MODE_TRIG   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } sched_state_e;

endpackage

// File: rtl/lut_cfg_field.sv
// rtl/lut_cfg_field.sv - one shadow/live/pending/wstb slice of the LUT configuration
module lut_cfg_field #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         apply_i,
    output logic [W-1:0] live_o,
    output logic         wstb_o,
    output logic         pending_o
);

    logic [W-1:0] shadow;
    logic         take;

    // A write landing in the apply cycle is forwarded straight into the live value
    assign take = apply_i && (pending_o || wr_i);

    // Shadow capture, atomic copy to live, and the matching one-cycle update strobe
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow    <= RST_VAL;
            live_o    <= RST_VAL;
            wstb_o    <= 1'b0;
            pending_o <= 1'b0;
        end else begin
            if (wr_i) begin
                shadow <= wdata_i;
            end
            wstb_o <= take;
            if (take) begin
                live_o    <= wr_i ? wdata_i : shadow;
                pending_o <= 1'b0;
            end else if (wr_i) begin
                pending_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lut_cfg_sched.sv
// rtl/lut_cfg_sched.sv - atomic immediate/commit/trigger scheduler for LUT configuration
module lut_cfg_sched
    import lut_pkg::*;
#(
    parameter logic [31:0] FUNC_RST    = 32'h0000_0000,
    parameter logic [1:0]  EDGE_RST    = 2'b00,
    parameter int unsigned ARM_TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [2:0]  reg_addr_i,
    input  logic [31:0] reg_data_i,
    input  logic        reg_wstb_i,
    input  logic [1:0]  mode_i,
    input  logic        commit_i,
    input  logic        trig_i,
    input  logic        abort_i,
    output logic [31:0] func_o,
    output logic        func_wstb_o,
    output logic [1:0]  a_o,
    output logic [1:0]  b_o,
    output logic [1:0]  c_o,
    output logic [1:0]  d_o,
    output logic [1:0]  e_o,
    output logic        a_wstb_o,
    output logic        b_wstb_o,
    output logic        c_wstb_o,
    output logic        d_wstb_o,
    output logic        e_wstb_o,
    output logic [5:0]  pending_o,
    output logic        busy_o,
    output logic        applied_o,
    output logic        err_o
);

    localparam logic [31:0] TO_LAST = 32'(ARM_TIMEOUT - 1);

    sched_state_e state, state_d;
    mode_e        cur_mode;
    logic [31:0]  arm_cnt;
    logic         trig_q;
    logic         trig_rise;
    logic         timeout_hit;
    logic         do_apply;
    logic         do_timeout;
    logic         wr_legal;
    logic         wr_illegal;
    logic         edge_rsvd;

    logic [NUM_FIELDS-1:0] fld_wr;
    logic [NUM_FIELDS-1:0] fld_wstb;
    logic [NUM_FIELDS-1:0] fld_pend;
    logic [1:0]            edge_live [1:NUM_FIELDS-1];

    // Reserved edge code only matters for the edge fields; FUNC takes any data
    assign edge_rsvd  = (edge_mode_e'(reg_data_i[1:0]) == EDGE_RSVD) && (reg_addr_i != FUNC_IDX);
    assign wr_legal   = reg_wstb_i && (reg_addr_i <= E_IDX) && !edge_rsvd;
    assign wr_illegal = reg_wstb_i && !wr_legal;

    assign cur_mode    = (mode_i == 2'd3) ? MODE_COMMIT : mode_e'(mode_i);
    assign trig_rise   = trig_i && !trig_q;
    assign timeout_hit = (ARM_TIMEOUT != 0) && (arm_cnt == TO_LAST);

    // Next-state and apply decision; abort beats trigger, trigger beats timeout
    always_comb begin
        state_d    = state;
        do_apply   = 1'b0;
        do_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cur_mode == MODE_IMMED) begin
                    if (wr_legal) begin
                        do_apply = 1'b1;
                        state_d  = ST_APPLY;
                    end
                end else if (cur_mode == MODE_TRIG) begin
                    if (commit_i) begin
                        state_d = ST_ARMED;
                    end
                end else if (commit_i) begin
                    do_apply = 1'b1;
                    state_d  = ST_APPLY;
                end
            end
            ST_ARMED: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (trig_rise) begin
                    do_apply = 1'b1;
                    state_d  = ST_APPLY;
                end else if (timeout_hit) begin
                    do_timeout = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register, armed-wait counter, trigger history and error pulse
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= ST_IDLE;
            arm_cnt <= 32'd0;
            trig_q  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_d;
            arm_cnt <= (state == ST_ARMED) ? arm_cnt + 32'd1 : 32'd0;
            trig_q  <= trig_i;
            err_o   <= wr_illegal || do_timeout;
        end
    end

    assign busy_o    = (state != ST_IDLE);
    assign applied_o = (state == ST_APPLY);

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_wr
        assign fld_wr[gi] = wr_legal && (reg_addr_i == 3'(gi));
    end

    lut_cfg_field #(
        .W       (32),
        .RST_VAL (FUNC_RST)
    ) u_func (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .wr_i      (fld_wr[0]),
        .wdata_i   (reg_data_i),
        .apply_i   (do_apply),
        .live_o    (func_o),
        .wstb_o    (fld_wstb[0]),
        .pending_o (fld_pend[0])
    );

    for (genvar gi = 1; gi < NUM_FIELDS; gi++) begin : g_edge
        lut_cfg_field #(
            .W       (2),
            .RST_VAL (EDGE_RST)
        ) u_edge (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .wr_i      (fld_wr[gi]),
            .wdata_i   (reg_data_i[1:0]),
            .apply_i   (do_apply),
            .live_o    (edge_live[gi]),
            .wstb_o    (fld_wstb[gi]),
            .pending_o (fld_pend[gi])
        );
    end

    assign a_o = edge_live[1];
    assign b_o = edge_live[2];
    assign c_o = edge_live[3];
    assign d_o = edge_live[4];
    assign e_o = edge_live[5];

    assign func_wstb_o = fld_wstb[0];
    assign a_wstb_o    = fld_wstb[1];
    assign b_wstb_o    = fld_wstb[2];
    assign c_wstb_o    = fld_wstb[3];
    assign d_wstb_o    = fld_wstb[4];
    assign e_wstb_o    = fld_wstb[5];

    assign pending_o = fld_pend;

endmodule
